// File: rtl/axi4_lite_conv_mac_slave.sv
// rtl/axi4_lite_conv_mac_slave.sv - AXI4-Lite slave with a 9-tap signed 8-bit sequential MAC engine.
module axi4_lite_conv_mac_slave #(
  parameter int ADDR_BITS = 8,
  parameter int TAPS      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic        irq_done
);
  localparam int WA = ADDR_BITS - 2;
  localparam int IW = $clog2(TAPS);
  localparam logic [WA-1:0] A_CTRL   = WA'(0);
  localparam logic [WA-1:0] A_STATUS = WA'(1);
  localparam logic [WA-1:0] A_RESULT = WA'(2);
  localparam logic [WA-1:0] A_W      = WA'(4);
  localparam logic [WA-1:0] A_X      = WA'(16);
  localparam logic [IW-1:0] LAST     = IW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;

  logic              aw_held, w_held, w_strb0;
  logic [WA-1:0]     aw_word;
  logic [7:0]        w_byte;
  logic signed [7:0] w_reg [TAPS];
  logic signed [7:0] x_reg [TAPS];
  logic [IW-1:0]     idx;
  logic [31:0]       acc, result;
  logic              done, busy, commit, wr_ok, start, in_w, in_x;
  logic [IW-1:0]     w_sel, x_sel, r_w_sel, r_x_sel;
  logic signed [15:0] prod;
  logic [WA-1:0]     rd_word;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign unused_bits = ^{axi_awaddr[31:ADDR_BITS], axi_awaddr[1:0], axi_araddr[31:ADDR_BITS],
                         axi_araddr[1:0], axi_awprot, axi_arprot, axi_wdata[31:8], axi_wstrb[3:1]};

  assign busy        = (state != IDLE);
  assign axi_awready = !reset && !aw_held && !axi_bvalid;
  assign axi_wready  = !reset && !w_held && !axi_bvalid;
  assign axi_arready = !reset && !axi_rvalid;
  assign commit      = aw_held && w_held && !axi_bvalid;
  assign wr_ok       = commit && w_strb0;
  assign start       = wr_ok && (aw_word == A_CTRL) && w_byte[0];
  assign in_w        = (aw_word >= A_W) && (aw_word < A_W + WA'(TAPS));
  assign in_x        = (aw_word >= A_X) && (aw_word < A_X + WA'(TAPS));
  assign w_sel       = IW'(aw_word - A_W);
  assign x_sel       = IW'(aw_word - A_X);
  assign prod        = w_reg[idx] * x_reg[idx];

  // AW and W are captured independently; the write commits once both holds are full.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_word    <= '0;
      w_byte     <= '0;
      w_strb0    <= 1'b0;
      axi_bvalid <= 1'b0;
    end else begin
      if (axi_awvalid && axi_awready) begin
        aw_held <= 1'b1;
        aw_word <= axi_awaddr[ADDR_BITS-1:2];
      end
      if (axi_wvalid && axi_wready) begin
        w_held  <= 1'b1;
        w_byte  <= axi_wdata[7:0];
        w_strb0 <= axi_wstrb[0];
      end
      if (commit) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        axi_bvalid <= 1'b1;
      end else if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        w_reg[i] <= '0;
        x_reg[i] <= '0;
      end
    end else if (wr_ok && !busy) begin
      if (in_w) w_reg[w_sel] <= w_byte;
      if (in_x) x_reg[x_sel] <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      idx      <= '0;
      result   <= '0;
      done     <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      irq_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc  <= '0;
          idx  <= '0;
          done <= 1'b0;
        end
        RUN: begin
          acc <= acc + {{16{prod[15]}}, prod};
          if (idx != LAST) idx <= idx + 1'b1;
        end
        FINISH: begin
          result   <= acc;
          done     <= 1'b1;
          irq_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_word = axi_araddr[ADDR_BITS-1:2];
  assign r_w_sel = IW'(rd_word - A_W);
  assign r_x_sel = IW'(rd_word - A_X);

  always_comb begin
    rd_mux = '0;
    if (rd_word == A_STATUS)
      rd_mux = {30'd0, done, busy};
    else if (rd_word == A_RESULT)
      rd_mux = result;
    else if ((rd_word >= A_W) && (rd_word < A_W + WA'(TAPS)))
      rd_mux = {{24{w_reg[r_w_sel][7]}}, w_reg[r_w_sel]};
    else if ((rd_word >= A_X) && (rd_word < A_X + WA'(TAPS)))
      rd_mux = {{24{x_reg[r_x_sel][7]}}, x_reg[r_x_sel]};
  end

  // rdata is only reloaded on a new address handshake so it stays stable while rvalid waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
    end else if (axi_arvalid && axi_arready) begin
      axi_rvalid <= 1'b1;
      axi_rdata  <= rd_mux;
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4_lite_conv_mac_slave.sv
// tb/tb_axi4_lite_conv_mac_slave.sv - directed self-checking bench for axi4_lite_conv_mac_slave.
module tb_axi4_lite_conv_mac_slave;
  logic        clk = 1'b0;
  logic        reset;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, irq_done;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int irq_count = 0;
  int irq_cyc = 0;
  int last_b_cyc = 0;

  axi4_lite_conv_mac_slave dut (
    .clk(clk), .reset(reset),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .irq_done(irq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (irq_done) begin irq_count++; irq_cyc = cyc; end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t;
    logic aw_fire, w_fire;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    t = 0;
    while ((axi_awvalid || axi_wvalid) && t < 50) begin
      aw_fire = axi_awvalid && axi_awready;
      w_fire  = axi_wvalid && axi_wready;
      @(negedge clk);
      if (aw_fire) axi_awvalid = 1'b0;
      if (w_fire) axi_wvalid = 1'b0;
      t++;
    end
    while (!axi_bvalid && t < 50) begin @(negedge clk); t++; end
    check("wr_timeout", 32'(t < 50), 32'd1);
    last_b_cyc = cyc;
    @(negedge clk);
    axi_bready = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int t;
    axi_araddr = addr; axi_arvalid = 1'b1;
    t = 0;
    while (!axi_arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    axi_arvalid = 1'b0;
    while (!axi_rvalid && t < 50) begin @(negedge clk); t++; end
    check("rd_timeout", 32'(t < 50), 32'd1);
    data = axi_rdata;
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
  endtask

  task automatic poll_done();
    logic [31:0] st;
    int n;
    n = 0;
    st = '0;
    while (!st[1] && n < 40) begin axi_read(32'h04, st); n++; end
    check("poll_done", {31'd0, st[1]}, 32'd1);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 9; i++) begin
      axi_write(32'h10 + 32'(4 * i), 32'd1, 4'hF);
      axi_write(32'h40 + 32'(4 * i), 32'(i + 1), 4'hF);
    end
  endtask

  initial begin
    logic [31:0] d;
    int base, b_start, t;
    reset = 1'b1;
    axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_rready = 0;
    axi_awaddr = 0; axi_wdata = 0; axi_wstrb = 0; axi_araddr = 0; axi_awprot = 0; axi_arprot = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, axi_awready}, 32'd0);
    check("rst_wready", {31'd0, axi_wready}, 32'd0);
    check("rst_arready", {31'd0, axi_arready}, 32'd0);
    check("rst_outs", {28'd0, axi_bvalid, axi_rvalid, irq_done, 1'b0}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_awready", {31'd0, axi_awready}, 32'd1);
    axi_read(32'h04, d); check("rst_status", d, 32'd0);
    axi_read(32'h08, d); check("rst_result", d, 32'd0);

    // Test 1: ramp dot product
    load_ramp();
    base = irq_count;
    axi_write(32'h00, 32'd1, 4'hF);
    b_start = last_b_cyc;
    axi_read(32'h04, d); check("t1_busy", d, 32'd1);
    poll_done();
    repeat (3) @(negedge clk);
    check("t1_irq_count", 32'(irq_count - base), 32'd1);
    check("t1_busy_cycles", 32'(irq_cyc - b_start), 32'd10);
    axi_read(32'h08, d); check("t1_result", d, 32'h2D);
    axi_read(32'h04, d); check("t1_status_done", d, 32'd2);
    axi_read(32'h00, d); check("t1_ctrl_reads0", d, 32'd0);

    // Test 2: extreme signed values
    axi_write(32'h10, 32'h80, 4'hF);
    axi_write(32'h40, 32'h7F, 4'hF);
    for (int i = 1; i < 9; i++) begin
      axi_write(32'h10 + 32'(4 * i), 32'd0, 4'hF);
      axi_write(32'h40 + 32'(4 * i), 32'd0, 4'hF);
    end
    axi_write(32'h00, 32'd1, 4'hF);
    poll_done();
    axi_read(32'h08, d); check("t2_result", d, 32'hFFFFC080);
    axi_read(32'h10, d); check("t2_w0_sext", d, 32'hFFFFFF80);
    axi_read(32'h40, d); check("t2_x0", d, 32'h7F);
    axi_write(32'h10, 32'h05, 4'b1110);
    axi_read(32'h10, d); check("t2_strb0_drop", d, 32'hFFFFFF80);

    // Test 3: W leads AW by 3 cycles, bready held low
    @(negedge clk);
    axi_wdata = 32'h05; axi_wstrb = 4'h1; axi_wvalid = 1'b1; axi_bready = 1'b0;
    @(negedge clk);
    axi_wvalid = 1'b0;
    check("t3_wready_held", {31'd0, axi_wready}, 32'd0);
    check("t3_awready_open", {31'd0, axi_awready}, 32'd1);
    repeat (2) @(negedge clk);
    axi_awaddr = 32'h4C; axi_awvalid = 1'b1;
    @(negedge clk);
    axi_awvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("t3_bvalid_hold", {31'd0, axi_bvalid}, 32'd1);
      check("t3_readies_low", {30'd0, axi_awready, axi_wready}, 32'd0);
      @(negedge clk);
    end
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    check("t3_bvalid_drop", {31'd0, axi_bvalid}, 32'd0);
    check("t3_readies_back", {30'd0, axi_awready, axi_wready}, 32'd3);
    axi_read(32'h4C, d); check("t3_x3", d, 32'h05);

    // Test 4: writes while busy are dropped
    base = irq_count;
    axi_write(32'h00, 32'd1, 4'hF);
    axi_write(32'h48, 32'h11, 4'hF);
    axi_write(32'h00, 32'd1, 4'hF);
    poll_done();
    repeat (15) @(negedge clk);
    check("t4_irq_once", 32'(irq_count - base), 32'd1);
    axi_read(32'h08, d); check("t4_result", d, 32'hFFFFC080);
    axi_read(32'h48, d); check("t4_x2_dropped", d, 32'd0);

    // Test 5: unmapped read with rready stalled
    @(negedge clk);
    axi_araddr = 32'h0C; axi_arvalid = 1'b1; axi_rready = 1'b0;
    @(negedge clk);
    axi_arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t5_rvalid", {31'd0, axi_rvalid}, 32'd1);
      check("t5_rdata", axi_rdata, 32'd0);
      check("t5_arready_low", {31'd0, axi_arready}, 32'd0);
      @(negedge clk);
    end
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
    check("t5_rvalid_drop", {31'd0, axi_rvalid}, 32'd0);
    check("t5_arready_back", {31'd0, axi_arready}, 32'd1);

    // Test 6: reset in the middle of RUN
    load_ramp();
    base = irq_count;
    axi_write(32'h00, 32'd1, 4'hF);
    b_start = last_b_cyc;
    t = 0;
    while (cyc < b_start + 4 && t < 50) begin @(negedge clk); t++; end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_irq", 32'(irq_count - base), 32'd0);
    axi_read(32'h04, d); check("t6_status", d, 32'd0);
    axi_read(32'h08, d); check("t6_result", d, 32'd0);
    axi_read(32'h10, d); check("t6_w0_cleared", d, 32'd0);
    load_ramp();
    axi_write(32'h00, 32'd1, 4'hF);
    poll_done();
    repeat (3) @(negedge clk);
    check("t6_irq_restart", 32'(irq_count - base), 32'd1);
    axi_read(32'h08, d); check("t6_result_restart", d, 32'h2D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
